rs_dsp_mult_arbiter: RTL

//  Shares one DSP38 in MULTIPY mode, with input and output registers enabled, between
//  NUM_REQ requesters. Arbitration is round-robin.

---
 rtl/rs_dsp_pkg.sv | 18 +
 rtl/rs_rr_arbiter.sv | 47 ++++
 rtl/rs_dsp_mult_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rs_dsp_pkg.sv
// Shared DSP38 multiplier constants and the in-flight tag type.
// Tag ids are sized for the largest supported requester count.
package rs_dsp_pkg;

  localparam int DSP_A_W          = 20;
  localparam int DSP_B_W          = 18;
  localparam int DSP_Z_W          = 38;
  localparam int DSP_MULT_LATENCY = 2;

  localparam int MAX_REQ  = 8;
  localparam int TAG_ID_W = $clog2(MAX_REQ);

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } dsp_tag_t;

endpackage

// File: rtl/rs_rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or after ptr.
// ptr moves one past the winner on every grant.
module rs_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  logic [ID_W-1:0] ptr;

  // search from ptr upward with wraparound
  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (enable && !grant_vld && req[j]) begin
        grant_vld = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

  // advance past the winner, holding when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_vld) begin
      if (grant_idx == ID_W'(NUM_REQ - 1))
        ptr <= '0;
      else
        ptr <= grant_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/rs_dsp_mult_arbiter.sv
// Shares one DSP38 multiplier among NUM_REQ clients, round-robin.
// Owner ids ride a tag pipe matched to the DSP latency.
module rs_dsp_mult_arbiter
  import rs_dsp_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int LATENCY = DSP_MULT_LATENCY,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       lreset,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DSP_A_W-1:0] req_a,
  input  logic [NUM_REQ*DSP_B_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]         req_unsigned_a,
  input  logic [NUM_REQ-1:0]         req_unsigned_b,
  output logic [DSP_A_W-1:0]         dsp_a,
  output logic [DSP_B_W-1:0]         dsp_b,
  output logic                       dsp_unsigned_a,
  output logic                       dsp_unsigned_b,
  output logic [2:0]                 dsp_feedback,
  input  logic [DSP_Z_W-1:0]         dsp_z,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DSP_Z_W-1:0]         rsp_z,
  output logic                       idle
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gidx;
  logic               gvld;

  logic [DSP_A_W-1:0] sel_a;
  logic [DSP_B_W-1:0] sel_b;
  logic               sel_ua;
  logic               sel_ub;

  logic [DSP_A_W-1:0] a_q;
  logic [DSP_B_W-1:0] b_q;
  logic               ua_q;
  logic               ub_q;

  dsp_tag_t tag_q [LATENCY];
  dsp_tag_t tag_last;
  logic     busy;

  rs_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (lreset),
    .enable    (enable & ~lreset),
    .req       (req_valid),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_vld (gvld)
  );

  assign req_ready = grant;

  // pick the winner's operands
  always_comb begin
    sel_a  = req_a[int'(gidx)*DSP_A_W +: DSP_A_W];
    sel_b  = req_b[int'(gidx)*DSP_B_W +: DSP_B_W];
    sel_ua = req_unsigned_a[gidx];
    sel_ub = req_unsigned_b[gidx];
  end

  // keep last issued operands so DSP pins stay quiet when idle
  always_ff @(posedge clk or posedge lreset) begin
    if (lreset) begin
      a_q  <= '0;
      b_q  <= '0;
      ua_q <= 1'b0;
      ub_q <= 1'b0;
    end else if (gvld) begin
      a_q  <= sel_a;
      b_q  <= sel_b;
      ua_q <= sel_ua;
      ub_q <= sel_ub;
    end
  end

  assign dsp_a          = gvld ? sel_a  : a_q;
  assign dsp_b          = gvld ? sel_b  : b_q;
  assign dsp_unsigned_a = gvld ? sel_ua : ua_q;
  assign dsp_unsigned_b = gvld ? sel_ub : ub_q;
  assign dsp_feedback   = 3'b000;

  // owner tags march alongside the DSP pipeline
  always_ff @(posedge clk or posedge lreset) begin
    if (lreset) begin
      for (int i = 0; i < LATENCY; i++)
        tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {gvld, TAG_ID_W'(gidx)};
      for (int i = 1; i < LATENCY; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_last = tag_q[LATENCY-1];
  assign rsp_id   = tag_last.id[ID_W-1:0];
  assign rsp_z    = dsp_z;

  // one-hot response strobe from the oldest tag
  always_comb begin
    rsp_valid = '0;
    if (tag_last.vld)
      rsp_valid[tag_last.id[ID_W-1:0]] = 1'b1;
  end

  // anything still travelling through the DSP
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++)
      busy = busy | tag_q[i].vld;
  end

  assign idle = ~|req_ready & ~busy;

endmodule
